shift_exec_stage: RTL and testbench

Two-stage, elastic execution stage for the ALU's shift operations. It accepts shift requests over a valid/ready handshake, selects among the existing combinational shifters (`shift_left_logical`, `shift_right_logical`, `shift_right_arithmetic`), and registers the result into a downstream-facing output stage. It sits between the operand-dispatch logic and the writeback path. It absorbs backpressure without dropping or reordering results.

---
 rtl/shift_pkg.sv | 14 +
 rtl/shift_left_logical.sv | 13 +
 rtl/shift_pipe_reg.sv | 33 +++
 rtl/shift_right_arithmetic.sv | 13 +
 rtl/shift_right_logical.sv | 13 +
 rtl/shift_exec_stage.sv | 139 +++++++++++++
 tb/tb_shift_exec_stage.sv | 367 ++++++++++++++++++++++++++++++++++++
 7 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the shift execution stage.
package shift_pkg;

    localparam int SHIFT_N    = 32;
    localparam int SHIFT_SH_W = $clog2(SHIFT_N);

    typedef enum logic [1:0] {
        SHIFT_SLL     = 2'b00,
        SHIFT_SRL     = 2'b01,
        SHIFT_SRA     = 2'b10,
        SHIFT_ILLEGAL = 2'b11
    } shift_op_t;

endpackage

// File: rtl/shift_left_logical.sv
// Combinational logical left shift, zero fill.
module shift_left_logical #(
    parameter int N    = 32,
    parameter int SH_W = $clog2(N)
) (
    input  logic [N-1:0]    i_data,
    input  logic [SH_W-1:0] i_shamt,
    output logic [N-1:0]    o_data
);

    assign o_data = i_data << i_shamt;

endmodule

// File: rtl/shift_pipe_reg.sv
// One pipeline slot: valid flag plus payload, load has priority over clear.
module shift_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Slot update: a load while being drained replaces the content, no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/shift_right_arithmetic.sv
// Combinational arithmetic right shift, sign fill.
module shift_right_arithmetic #(
    parameter int N    = 32,
    parameter int SH_W = $clog2(N)
) (
    input  logic [N-1:0]    i_data,
    input  logic [SH_W-1:0] i_shamt,
    output logic [N-1:0]    o_data
);

    assign o_data = $signed(i_data) >>> i_shamt;

endmodule

// File: rtl/shift_right_logical.sv
// Combinational logical right shift, zero fill.
module shift_right_logical #(
    parameter int N    = 32,
    parameter int SH_W = $clog2(N)
) (
    input  logic [N-1:0]    i_data,
    input  logic [SH_W-1:0] i_shamt,
    output logic [N-1:0]    o_data
);

    assign o_data = i_data >> i_shamt;

endmodule

// File: rtl/shift_exec_stage.sv
// Two-slot elastic shift execution stage: S1 holds operands, S2 holds the
// registered result. Backpressure ripples combinationally from out_ready to in_ready.
module shift_exec_stage
    import shift_pkg::*;
#(
    parameter int N     = SHIFT_N,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [N-1:0]         in_data,
    input  logic [$clog2(N)-1:0] in_shamt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_data,
    output logic                 out_err,
    output logic                 err_sticky,
    output logic [CNT_W-1:0]     done_count
);

    localparam int SH_W = $clog2(N);
    localparam int S1_W = 2 + N + SH_W;
    localparam int S2_W = 1 + N;

    logic            w_s1_valid;
    logic            w_s2_valid;
    logic            w_s1_adv;
    logic            w_s2_adv;
    logic            w_in_fire;
    logic            w_out_fire;
    logic [S1_W-1:0] w_s1_d;
    logic [S1_W-1:0] w_s1_q;
    logic [S2_W-1:0] w_s2_d;
    logic [S2_W-1:0] w_s2_q;
    logic [1:0]      w_s1_op_bits;
    shift_op_t       w_s1_op;
    logic [N-1:0]    w_s1_data;
    logic [SH_W-1:0] w_s1_shamt;
    logic [N-1:0]    w_sll;
    logic [N-1:0]    w_srl;
    logic [N-1:0]    w_sra;
    logic [N-1:0]    w_result;
    logic            w_err;

    logic             r_err_sticky;
    logic [CNT_W-1:0] r_done_count;

    assign w_s2_adv   = !w_s2_valid || out_ready;
    assign w_s1_adv   = w_s1_valid && w_s2_adv;
    assign in_ready   = !w_s1_valid || w_s2_adv;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = w_s2_valid && out_ready;

    assign w_s1_d = {in_op, in_data, in_shamt};

    shift_pipe_reg #(.W(S1_W)) u_s1 (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_in_fire),
        .i_clear (w_s1_adv),
        .i_data  (w_s1_d),
        .o_valid (w_s1_valid),
        .o_data  (w_s1_q)
    );

    assign {w_s1_op_bits, w_s1_data, w_s1_shamt} = w_s1_q;
    assign w_s1_op = shift_op_t'(w_s1_op_bits);

    shift_left_logical #(.N(N), .SH_W(SH_W)) u_sll (
        .i_data  (w_s1_data),
        .i_shamt (w_s1_shamt),
        .o_data  (w_sll)
    );

    shift_right_logical #(.N(N), .SH_W(SH_W)) u_srl (
        .i_data  (w_s1_data),
        .i_shamt (w_s1_shamt),
        .o_data  (w_srl)
    );

    shift_right_arithmetic #(.N(N), .SH_W(SH_W)) u_sra (
        .i_data  (w_s1_data),
        .i_shamt (w_s1_shamt),
        .o_data  (w_sra)
    );

    // Op mux: illegal op yields zero result with the error flag set.
    always_comb begin
        w_result = '0;
        w_err    = 1'b0;
        case (w_s1_op)
            SHIFT_SLL:     w_result = w_sll;
            SHIFT_SRL:     w_result = w_srl;
            SHIFT_SRA:     w_result = w_sra;
            SHIFT_ILLEGAL: w_err    = 1'b1;
            default:       w_err    = 1'b1;
        endcase
    end

    assign w_s2_d = {w_err, w_result};

    shift_pipe_reg #(.W(S2_W)) u_s2 (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_s1_adv),
        .i_clear (w_out_fire),
        .i_data  (w_s2_d),
        .o_valid (w_s2_valid),
        .o_data  (w_s2_q)
    );

    assign out_valid           = w_s2_valid;
    assign {out_err, out_data} = w_s2_q;

    // Sticky error: set when an illegal op enters S1, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
        end else if (w_in_fire && (shift_op_t'(in_op) == SHIFT_ILLEGAL)) begin
            r_err_sticky <= 1'b1;
        end
    end

    // Completed-result counter, free-running wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_count <= '0;
        end else if (w_out_fire) begin
            r_done_count <= r_done_count + 1'b1;
        end
    end

    assign err_sticky = r_err_sticky;
    assign done_count = r_done_count;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Self-checking bench for shift_exec_stage with a queue-based reference model.
module tb_shift_exec_stage;

    localparam int N     = 32;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [N-1:0]     in_data;
    logic [4:0]       in_shamt;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_data;
    logic             out_err;
    logic             err_sticky;
    logic [CNT_W-1:0] done_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_exec_stage #(.N(N), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_data    (in_data),
        .in_shamt   (in_shamt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_err    (out_err),
        .err_sticky (err_sticky),
        .done_count (done_count)
    );

    // Reference model: ordered queue of results in flight, each with its age in edges.
    typedef struct {
        logic [31:0] data;
        logic        err;
        int unsigned age;
    } item_t;

    item_t       q[$];
    logic        m_sticky;
    logic [31:0] m_count;
    logic        exp_in_ready;
    logic        exp_out_valid;
    logic [31:0] exp_data;
    logic        exp_err;

    // Result defined bit by bit: repeat a one-position shift 'sh' times.
    function automatic logic [32:0] ref_result(input logic [1:0] op, input logic [31:0] d,
                                               input logic [4:0] sh);
        logic [31:0] r;
        r = d;
        if (op == 2'b11) return {1'b1, 32'h0};
        for (int unsigned i = 0; i < 32'(sh); i++) begin
            case (op)
                2'b00:   r = {r[30:0], 1'b0};
                2'b01:   r = {1'b0, r[31:1]};
                default: r = {r[31], r[31:1]};
            endcase
        end
        return {1'b0, r};
    endfunction

    task automatic model_reset();
        q.delete();
        m_sticky = 1'b0;
        m_count  = '0;
    endtask

    // Capacity two; a result becomes visible one edge after its operands were captured.
    task automatic model_expect();
        exp_out_valid = (q.size() > 0) && (q[0].age >= 1);
        exp_in_ready  = (q.size() < 2) || out_ready;
        exp_data      = (q.size() > 0) ? q[0].data : 32'h0;
        exp_err       = (q.size() > 0) ? q[0].err : 1'b0;
    endtask

    task automatic model_edge();
        logic        acc;
        logic        cons;
        logic [32:0] r;
        item_t       it;
        acc  = in_valid && exp_in_ready;
        cons = exp_out_valid && out_ready;
        if (cons) begin
            void'(q.pop_front());
            m_count = m_count + 1;
        end
        foreach (q[i]) q[i].age = q[i].age + 1;
        if (acc) begin
            r       = ref_result(in_op, in_data, in_shamt);
            it.err  = r[32];
            it.data = r[31:0];
            it.age  = 0;
            q.push_back(it);
            if (in_op == 2'b11) m_sticky = 1'b1;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_expect();
    endtask

    task automatic advance();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [1:0] op, input logic [31:0] d,
                           input logic [4:0] sh);
        in_valid = v;
        in_op    = op;
        in_data  = d;
        in_shamt = sh;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        out_ready = 1'b0;
        set_req(1'b0, 2'b00, 32'h0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        sample();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_err_sticky got=%b exp=0", err_sticky); end
        checks++; if (done_count !== 32'h0) begin errors++; $display("FAIL reset_done_count got=%0d exp=0", done_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        advance();
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] d;
        logic [4:0]  sh;
        logic [31:0] res;
    } vec_t;

    task automatic test_directed();
        vec_t v[9];
        v = '{'{2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000},
              '{2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000},
              '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000},
              '{2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000},
              '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF},
              '{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001},
              '{2'b00, 32'hA5A5_5A5A, 5'd0,  32'hA5A5_5A5A},
              '{2'b01, 32'hA5A5_5A5A, 5'd0,  32'hA5A5_5A5A},
              '{2'b10, 32'hA5A5_5A5A, 5'd0,  32'hA5A5_5A5A}};
        out_ready = 1'b1;
        foreach (v[i]) begin
            set_req(1'b1, v[i].op, v[i].d, v[i].sh);
            sample();
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir_in_ready vec=%0d got=%b exp=1", i, in_ready); end
            advance();
            set_req(1'b0, 2'b00, 32'h0, 5'd0);
            sample();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir_early_valid vec=%0d got=%b exp=0", i, out_valid); end
            advance();
            sample();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dir_valid vec=%0d got=%b exp=1", i, out_valid); end
            checks++; if (out_data !== v[i].res) begin errors++; $display("FAIL dir_data vec=%0d got=%h exp=%h", i, out_data, v[i].res); end
            checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL dir_err vec=%0d got=%b exp=0", i, out_err); end
            advance();
        end
    endtask

    task automatic test_backpressure();
        logic [1:0]  b_op[4];
        logic [31:0] b_d[4];
        logic [4:0]  b_sh[4];
        logic [32:0] b_exp[4];
        logic [31:0] got[$];
        logic [31:0] start_cnt;
        int          idx;
        for (int i = 0; i < 4; i++) begin
            b_op[i]  = 2'($urandom_range(0, 2));
            b_d[i]   = $urandom;
            b_sh[i]  = 5'($urandom_range(0, 31));
            b_exp[i] = ref_result(b_op[i], b_d[i], b_sh[i]);
        end
        start_cnt = m_count;
        idx       = 0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc == 4) out_ready = 1'b1;
            if (idx < 4) set_req(1'b1, b_op[idx], b_d[idx], b_sh[idx]);
            else set_req(1'b0, 2'b00, 32'h0, 5'd0);
            sample();
            if (cyc < 4) begin
                checks++; if (in_ready !== (cyc < 2)) begin errors++; $display("FAIL bp_fill_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, (cyc < 2)); end
            end
            if (cyc == 4) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
            end
            checks++; if (in_ready !== exp_in_ready) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_in_ready); end
            checks++; if (out_valid !== exp_out_valid) begin errors++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_out_valid); end
            if (exp_out_valid) begin
                checks++; if ({out_err, out_data} !== {exp_err, exp_data}) begin errors++; $display("FAIL bp_out_data cyc=%0d got=%b/%h exp=%b/%h", cyc, out_err, out_data, exp_err, exp_data); end
            end
            if (out_valid && out_ready) got.push_back(out_data);
            if (in_valid && exp_in_ready) idx++;
            advance();
            if (idx == 4 && q.size() == 0) break;
        end
        checks++; if (idx != 4 || q.size() != 0) begin errors++; $display("FAIL bp_timeout accepted=%0d pending=%0d exp=4/0", idx, q.size()); end
        checks++; if (got.size() != 4) begin errors++; $display("FAIL bp_result_count got=%0d exp=4", got.size()); end
        foreach (got[i]) begin
            if (i < 4) begin
                checks++; if (got[i] !== b_exp[i][31:0]) begin errors++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i, got[i], b_exp[i][31:0]); end
            end
        end
        sample();
        checks++; if (done_count !== start_cnt + 32'd4) begin errors++; $display("FAIL bp_done_count got=%0d exp=%0d", done_count, start_cnt + 32'd4); end
        advance();
    endtask

    task automatic test_streaming();
        int first_valid;
        int last_valid;
        int nres;
        int idx;
        first_valid = -1;
        last_valid  = -1;
        nres        = 0;
        idx         = 0;
        out_ready   = 1'b1;
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (idx < 16) set_req(1'b1, 2'($urandom_range(0, 2)), $urandom, 5'($urandom_range(0, 31)));
            else set_req(1'b0, 2'b00, 32'h0, 5'd0);
            sample();
            checks++; if (in_ready !== exp_in_ready) begin errors++; $display("FAIL st_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_in_ready); end
            checks++; if (out_valid !== exp_out_valid) begin errors++; $display("FAIL st_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_out_valid); end
            if (exp_out_valid) begin
                checks++; if ({out_err, out_data} !== {exp_err, exp_data}) begin errors++; $display("FAIL st_out_data cyc=%0d got=%b/%h exp=%b/%h", cyc, out_err, out_data, exp_err, exp_data); end
            end
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                last_valid = cyc;
                nres++;
            end
            if (in_valid && exp_in_ready) idx++;
            advance();
        end
        checks++; if (first_valid != 2) begin errors++; $display("FAIL st_latency got=%0d exp=2", first_valid); end
        checks++; if (nres != 16) begin errors++; $display("FAIL st_count got=%0d exp=16", nres); end
        checks++; if (last_valid != 17) begin errors++; $display("FAIL st_throughput last=%0d exp=17", last_valid); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (cyc == 0) set_req(1'b1, 2'b11, 32'hFFFF_FFFF, 5'd7);
            else if (cyc == 1) set_req(1'b1, 2'b00, 32'h0000_0001, 5'd1);
            else set_req(1'b0, 2'b00, 32'h0, 5'd0);
            sample();
            checks++; if (err_sticky !== (cyc != 0)) begin errors++; $display("FAIL ill_sticky cyc=%0d got=%b exp=%b", cyc, err_sticky, (cyc != 0)); end
            checks++; if (out_valid !== exp_out_valid) begin errors++; $display("FAIL ill_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_out_valid); end
            if (cyc == 2) begin
                checks++; if ({out_valid, out_err, out_data} !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL ill_beat got=%b/%b/%h exp=1/1/00000000", out_valid, out_err, out_data); end
            end
            if (cyc == 3) begin
                checks++; if ({out_valid, out_err, out_data} !== {1'b1, 1'b0, 32'h2}) begin errors++; $display("FAIL ill_next_beat got=%b/%b/%h exp=1/0/00000002", out_valid, out_err, out_data); end
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic pending;
        pending = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            out_ready = ($urandom_range(0, 99) < 60);
            if (!pending) begin
                if ($urandom_range(0, 99) < 70) begin
                    set_req(1'b1, 2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)));
                    pending = 1'b1;
                end else begin
                    set_req(1'b0, 2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)));
                end
            end
            sample();
            checks++; if (in_ready !== exp_in_ready) begin errors++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_in_ready); end
            checks++; if (out_valid !== exp_out_valid) begin errors++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_out_valid); end
            if (exp_out_valid) begin
                checks++; if ({out_err, out_data} !== {exp_err, exp_data}) begin errors++; $display("FAIL rnd_out_data cyc=%0d got=%b/%h exp=%b/%h", cyc, out_err, out_data, exp_err, exp_data); end
            end
            checks++; if (err_sticky !== m_sticky) begin errors++; $display("FAIL rnd_sticky cyc=%0d got=%b exp=%b", cyc, err_sticky, m_sticky); end
            checks++; if (done_count !== m_count) begin errors++; $display("FAIL rnd_done_count cyc=%0d got=%0d exp=%0d", cyc, done_count, m_count); end
            if (in_valid && exp_in_ready) pending = 1'b0;
            advance();
        end
        out_ready = 1'b1;
        set_req(1'b0, 2'b00, 32'h0, 5'd0);
        for (int cyc = 0; cyc < 10; cyc++) begin
            sample();
            if (exp_out_valid) begin
                checks++; if ({out_valid, out_err, out_data} !== {1'b1, exp_err, exp_data}) begin errors++; $display("FAIL rnd_drain cyc=%0d got=%b/%b/%h exp=1/%b/%h", cyc, out_valid, out_err, out_data, exp_err, exp_data); end
            end
            advance();
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_drain_timeout pending=%0d exp=0", q.size()); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            set_req(1'b1, 2'b00, $urandom, 5'($urandom_range(0, 31)));
            sample();
            checks++; if (in_ready !== (cyc < 2)) begin errors++; $display("FAIL rm_fill_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, (cyc < 2)); end
            advance();
        end
        rst = 1'b1;
        set_req(1'b1, 2'b11, 32'hFFFF_FFFF, 5'd3);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_req(1'b0, 2'b00, 32'h0, 5'd0);
        model_reset();
        sample();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready got=%b exp=1", in_ready); end
        checks++; if (done_count !== 32'h0) begin errors++; $display("FAIL rm_done_count got=%0d exp=0", done_count); end
        checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL rm_sticky got=%b exp=0", err_sticky); end
        advance();
        out_ready = 1'b1;
        set_req(1'b1, 2'b01, 32'hF000_000F, 5'd4);
        sample();
        advance();
        set_req(1'b0, 2'b00, 32'h0, 5'd0);
        sample();
        advance();
        sample();
        checks++; if ({out_valid, out_err, out_data} !== {1'b1, 1'b0, 32'h0F00_0000}) begin errors++; $display("FAIL rm_after_reset got=%b/%b/%h exp=1/0/0f000000", out_valid, out_err, out_data); end
        advance();
        sample();
        checks++; if (done_count !== 32'h1) begin errors++; $display("FAIL rm_count_after got=%0d exp=1", done_count); end
        advance();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_streaming();
        test_illegal();
        test_random();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
